// File: rtl/data_memory_unit.sv
// Data-memory front end for the MEM stage.
// The core port does byte/half/word(/double) accesses with lane write enables and a
// registered one-cycle read. A second read port feeds a debug FSM that streams every
// word out without touching the core port.
module data_memory_unit #(
   parameter int NB_DATA_BUS  = 32,
   parameter int N_ADDRESS    = 128,
   parameter int NB_ADDRESS   = $clog2(N_ADDRESS),
   parameter int N_LANES      = NB_DATA_BUS/8,
   parameter int N_WORDS      = N_ADDRESS/N_LANES,
   parameter int NB_WORD_ADDR = $clog2(N_WORDS)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NB_ADDRESS-1:0]   i_addr,
   input  logic [1:0]              i_addressing,
   input  logic                    i_r_en,
   input  logic                    i_r_signing,
   input  logic                    i_w_en,
   input  logic [NB_DATA_BUS-1:0]  i_w_data,
   output logic [NB_DATA_BUS-1:0]  o_r_data,
   output logic                    o_r_valid,
   output logic                    o_misaligned,
   input  logic                    i_d_start,
   output logic                    o_d_busy,
   output logic                    o_d_valid,
   output logic [NB_WORD_ADDR-1:0] o_d_addr,
   output logic [NB_DATA_BUS-1:0]  o_d_r_data,
   output logic                    o_d_done
);
   localparam int LB = $clog2(N_LANES);
   localparam logic [N_LANES-1:0] BE_B = N_LANES'(1);
   localparam logic [N_LANES-1:0] BE_H = N_LANES'(3);
   localparam logic [N_LANES-1:0] BE_W = N_LANES'(15);

   typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

   logic [NB_DATA_BUS-1:0]  r_mem [N_WORDS];

   logic [LB-1:0]           w_off;
   logic [NB_WORD_ADDR-1:0] w_word_addr;
   logic                    w_legal;
   logic                    w_we;
   logic                    w_re;
   logic [N_LANES-1:0]      w_be;
   logic [NB_DATA_BUS-1:0]  w_wdata;

   logic [NB_DATA_BUS-1:0]  r_rd_word;
   logic [LB-1:0]           r_off;
   logic [1:0]              r_size;
   logic                    r_sign;
   logic                    r_r_valid;
   logic                    r_misaligned;
   logic [NB_DATA_BUS-1:0]  w_shift;
   logic [NB_DATA_BUS-1:0]  w_ext_w;
   logic [NB_DATA_BUS-1:0]  w_ext;

   state_t                  r_state;
   logic [NB_WORD_ADDR-1:0] r_cnt;
   logic                    r_d_busy;
   logic                    r_d_valid;
   logic [NB_WORD_ADDR-1:0] r_d_addr;
   logic [NB_DATA_BUS-1:0]  r_d_data;
   logic                    r_d_done;

   assign w_off       = i_addr[LB-1:0];
   assign w_word_addr = i_addr[NB_ADDRESS-1:LB];

   // Alignment check, lane enables and replicated store data for the current request.
   always_comb begin
      w_legal = 1'b0;
      w_be    = '0;
      w_wdata = i_w_data;
      case (i_addressing)
         2'b00: begin
            w_legal = 1'b1;
            w_be    = BE_B << w_off;
            w_wdata = {N_LANES{i_w_data[7:0]}};
         end
         2'b01: begin
            w_legal = ~i_addr[0];
            w_be    = BE_H << w_off;
            w_wdata = {(N_LANES/2){i_w_data[15:0]}};
         end
         2'b11: begin
            w_legal = (i_addr[1:0] == 2'b00);
            w_be    = BE_W << w_off;
            w_wdata = {(N_LANES/4){i_w_data[31:0]}};
         end
         default: begin
            w_legal = (NB_DATA_BUS == 64) && (i_addr[2:0] == 3'b000);
            w_be    = '1;
            w_wdata = i_w_data;
         end
      endcase
   end

   // A write always beats a simultaneous read.
   assign w_we = i_w_en & w_legal;
   assign w_re = i_r_en & ~i_w_en & w_legal;

   // Byte-lane writes; memory contents are never reset.
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         for (int i = 0; i < N_LANES; i++) begin
            if (w_be[i]) r_mem[w_word_addr][i*8 +: 8] <= w_wdata[i*8 +: 8];
         end
      end
   end

   // Core read capture: RAM word plus the access shape, and the status strobes.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rd_word    <= '0;
         r_off        <= '0;
         r_size       <= 2'b00;
         r_sign       <= 1'b0;
         r_r_valid    <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_r_valid    <= w_re;
         r_misaligned <= (i_r_en | i_w_en) & ~w_legal;
         if (w_re) begin
            r_rd_word <= r_mem[w_word_addr];
            r_off     <= w_off;
            r_size    <= i_addressing;
            r_sign    <= i_r_signing;
         end
      end
   end

   assign w_shift = r_rd_word >> {r_off, 3'b000};

   generate
      if (NB_DATA_BUS == 64) begin : g_word64
         assign w_ext_w = {{(NB_DATA_BUS-32){r_sign & w_shift[31]}}, w_shift[31:0]};
      end else begin : g_word32
         assign w_ext_w = w_shift;
      end
   endgenerate

   // Extension of the selected field; holds while the capture registers hold.
   always_comb begin
      w_ext = w_shift;
      case (r_size)
         2'b00:   w_ext = {{(NB_DATA_BUS-8){r_sign & w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_ext = {{(NB_DATA_BUS-16){r_sign & w_shift[15]}}, w_shift[15:0]};
         2'b11:   w_ext = w_ext_w;
         default: w_ext = w_shift;
      endcase
   end

   assign o_r_data     = w_ext;
   assign o_r_valid    = r_r_valid;
   assign o_misaligned = r_misaligned;

   // Debug dump FSM on the second read port; the last word and done leave together.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_d_busy  <= 1'b0;
         r_d_valid <= 1'b0;
         r_d_addr  <= '0;
         r_d_data  <= '0;
         r_d_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_d_valid <= 1'b0;
               r_d_done  <= 1'b0;
               if (i_d_start) begin
                  r_state  <= S_DUMP;
                  r_cnt    <= '0;
                  r_d_busy <= 1'b1;
               end
            end
            S_DUMP: begin
               r_d_data  <= r_mem[r_cnt];
               r_d_addr  <= r_cnt;
               r_d_valid <= 1'b1;
               r_cnt     <= r_cnt + 1'b1;
               if (r_cnt == NB_WORD_ADDR'(N_WORDS-1)) begin
                  r_state  <= S_DONE;
                  r_d_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_d_valid <= 1'b0;
               r_d_done  <= 1'b0;
               r_d_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_d_busy   = r_d_busy;
   assign o_d_valid  = r_d_valid;
   assign o_d_addr   = r_d_addr;
   assign o_d_r_data = r_d_data;
   assign o_d_done   = r_d_done;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: a 32-bit build, a 64-bit build and a
// small 32-bit build (4 words) for the debug dump.
module tb_data_memory_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // 32-bit, 128-byte instance
   logic        rst = 1'b1;
   logic [6:0]  a_addr = '0;
   logic [1:0]  a_mode = '0;
   logic        a_r = 1'b0, a_s = 1'b0, a_w = 1'b0, a_start = 1'b0;
   logic [31:0] a_wd = '0, a_rd, a_ddata;
   logic        a_rv, a_mis, a_busy, a_dv, a_done;
   logic [4:0]  a_daddr;

   data_memory_unit #(.NB_DATA_BUS(32), .N_ADDRESS(128)) u_a (
      .i_clk(clk), .i_reset(rst), .i_addr(a_addr), .i_addressing(a_mode),
      .i_r_en(a_r), .i_r_signing(a_s), .i_w_en(a_w), .i_w_data(a_wd),
      .o_r_data(a_rd), .o_r_valid(a_rv), .o_misaligned(a_mis),
      .i_d_start(a_start), .o_d_busy(a_busy), .o_d_valid(a_dv),
      .o_d_addr(a_daddr), .o_d_r_data(a_ddata), .o_d_done(a_done));

   // 64-bit, 128-byte instance
   logic [6:0]  b_addr = '0;
   logic [1:0]  b_mode = '0;
   logic        b_r = 1'b0, b_s = 1'b0, b_w = 1'b0, b_start = 1'b0;
   logic [63:0] b_wd = '0, b_rd, b_ddata;
   logic        b_rv, b_mis, b_busy, b_dv, b_done;
   logic [3:0]  b_daddr;

   data_memory_unit #(.NB_DATA_BUS(64), .N_ADDRESS(128)) u_b (
      .i_clk(clk), .i_reset(rst), .i_addr(b_addr), .i_addressing(b_mode),
      .i_r_en(b_r), .i_r_signing(b_s), .i_w_en(b_w), .i_w_data(b_wd),
      .o_r_data(b_rd), .o_r_valid(b_rv), .o_misaligned(b_mis),
      .i_d_start(b_start), .o_d_busy(b_busy), .o_d_valid(b_dv),
      .o_d_addr(b_daddr), .o_d_r_data(b_ddata), .o_d_done(b_done));

   // 32-bit, 16-byte instance for dumps
   logic        c_rst = 1'b1;
   logic [3:0]  c_addr = '0;
   logic [1:0]  c_mode = '0;
   logic        c_r = 1'b0, c_s = 1'b0, c_w = 1'b0, c_start = 1'b0;
   logic [31:0] c_wd = '0, c_rd, c_ddata;
   logic        c_rv, c_mis, c_busy, c_dv, c_done;
   logic [1:0]  c_daddr;

   data_memory_unit #(.NB_DATA_BUS(32), .N_ADDRESS(16)) u_c (
      .i_clk(clk), .i_reset(c_rst), .i_addr(c_addr), .i_addressing(c_mode),
      .i_r_en(c_r), .i_r_signing(c_s), .i_w_en(c_w), .i_w_data(c_wd),
      .o_r_data(c_rd), .o_r_valid(c_rv), .o_misaligned(c_mis),
      .i_d_start(c_start), .o_d_busy(c_busy), .o_d_valid(c_dv),
      .o_d_addr(c_daddr), .o_d_r_data(c_ddata), .o_d_done(c_done));

   // Drive one core request for one cycle; outputs reflect it on return.
   task automatic a_set(input logic [6:0] ad, input logic [1:0] md, input logic r,
                        input logic s, input logic w, input logic [31:0] wd);
      a_addr = ad; a_mode = md; a_r = r; a_s = s; a_w = w; a_wd = wd;
      @(negedge clk);
      $display("A addr=%h mode=%b r=%b w=%b -> rd=%h rv=%b mis=%b", ad, md, r, w, a_rd, a_rv, a_mis);
   endtask

   task automatic a_idle();
      a_r = 1'b0; a_w = 1'b0;
      @(negedge clk);
   endtask

   task automatic b_set(input logic [6:0] ad, input logic [1:0] md, input logic r,
                        input logic s, input logic w, input logic [63:0] wd);
      b_addr = ad; b_mode = md; b_r = r; b_s = s; b_w = w; b_wd = wd;
      @(negedge clk);
      $display("B addr=%h mode=%b r=%b w=%b -> rd=%h rv=%b mis=%b", ad, md, r, w, b_rd, b_rv, b_mis);
      b_r = 1'b0; b_w = 1'b0;
   endtask

   task automatic c_set(input logic [3:0] ad, input logic [31:0] wd);
      c_addr = ad; c_mode = 2'b11; c_w = 1'b1; c_wd = wd;
      @(negedge clk);
      c_w = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if ({a_rd, a_rv, a_mis, a_busy, a_dv, a_daddr, a_ddata, a_done} !== '0) begin
         n_bad++; $display("FAIL reset_a got %h/%b/%b want all 0", a_rd, a_rv, a_mis); end
      n_cmp++; if ({b_rd, b_rv, b_mis, b_busy, b_dv, b_daddr, b_ddata, b_done} !== '0) begin
         n_bad++; $display("FAIL reset_b got %h/%b/%b want all 0", b_rd, b_rv, b_mis); end
      n_cmp++; if ({c_rd, c_rv, c_mis, c_busy, c_dv, c_daddr, c_ddata, c_done} !== '0) begin
         n_bad++; $display("FAIL reset_c got %h/%b want all 0", c_rd, c_busy); end
      rst = 1'b0; c_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_extension();
      a_set(7'h10, 2'b11, 1'b0, 1'b0, 1'b1, 32'h8899AABB);
      n_cmp++; if (a_rv !== 1'b0) begin n_bad++; $display("FAIL write_no_valid got %b want 0", a_rv); end
      a_set(7'h13, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'hFFFFFF88) begin
         n_bad++; $display("FAIL sbyte_13 got %h/%b want ffffff88/1", a_rd, a_rv); end
      a_set(7'h12, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'h00008899) begin
         n_bad++; $display("FAIL uhalf_12 got %h/%b want 00008899/1", a_rd, a_rv); end
      a_set(7'h11, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rd !== 32'h000000AA) begin n_bad++; $display("FAIL ubyte_11 got %h want 000000aa", a_rd); end
      a_set(7'h10, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (a_rd !== 32'hFFFFAABB) begin n_bad++; $display("FAIL shalf_10 got %h want ffffaabb", a_rd); end
      a_idle();
      n_cmp++; if (a_rv !== 1'b0 || a_rd !== 32'hFFFFAABB) begin
         n_bad++; $display("FAIL hold got %h/%b want ffffaabb/0", a_rd, a_rv); end
   endtask

   task automatic test_lanes();
      a_set(7'h20, 2'b11, 1'b0, 1'b0, 1'b1, 32'h11223344);
      a_set(7'h21, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFFFF5A);
      a_set(7'h20, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'h11225A44) begin
         n_bad++; $display("FAIL byte_lane got %h/%b want 11225a44/1", a_rd, a_rv); end
      a_set(7'h22, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000BEEF);
      a_set(7'h20, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rd !== 32'hBEEF5A44) begin n_bad++; $display("FAIL half_lane got %h want beef5a44", a_rd); end
      a_idle();
   endtask

   task automatic test_misaligned();
      a_set(7'h00, 2'b11, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
      a_set(7'h06, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_mis !== 1'b1 || a_rv !== 1'b0) begin
         n_bad++; $display("FAIL mis_word06 got mis=%b rv=%b want 1/0", a_mis, a_rv); end
      a_idle();
      n_cmp++; if (a_mis !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b want 0", a_mis); end
      a_set(7'h08, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_mis !== 1'b1 || a_rv !== 1'b0) begin
         n_bad++; $display("FAIL mis_code10 got mis=%b rv=%b want 1/0", a_mis, a_rv); end
      a_set(7'h03, 2'b01, 1'b0, 1'b0, 1'b1, 32'h00001234);
      n_cmp++; if (a_mis !== 1'b1) begin n_bad++; $display("FAIL mis_half03 got %b want 1", a_mis); end
      a_set(7'h00, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rd !== 32'hCAFEF00D || a_mis !== 1'b0) begin
         n_bad++; $display("FAIL mis_nowrite got %h/%b want cafef00d/0", a_rd, a_mis); end
      a_idle();
   endtask

   task automatic test_back_to_back();
      a_set(7'h30, 2'b11, 1'b0, 1'b0, 1'b1, 32'h13572468);
      a_set(7'h30, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'h13572468) begin
         n_bad++; $display("FAIL raw got %h/%b want 13572468/1", a_rd, a_rv); end
      a_set(7'h10, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'h8899AABB) begin
         n_bad++; $display("FAIL b2b_1 got %h/%b want 8899aabb/1", a_rd, a_rv); end
      a_set(7'h20, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (a_rv !== 1'b1 || a_rd !== 32'hBEEF5A44) begin
         n_bad++; $display("FAIL b2b_2 got %h/%b want beef5a44/1", a_rd, a_rv); end
      a_set(7'h30, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0000000F);
      n_cmp++; if (a_rv !== 1'b0) begin n_bad++; $display("FAIL rw_same got rv=%b want 0", a_rv); end
      a_idle();
   endtask

   task automatic test_64();
      b_set(7'h08, 2'b10, 1'b0, 1'b0, 1'b1, 64'h0123456789ABCDEF);
      b_set(7'h0C, 2'b11, 1'b1, 1'b1, 1'b0, 64'h0);
      n_cmp++; if (b_rv !== 1'b1 || b_rd !== 64'h0000000001234567) begin
         n_bad++; $display("FAIL b_sword0c got %h/%b want 0000000001234567/1", b_rd, b_rv); end
      b_set(7'h0F, 2'b00, 1'b1, 1'b1, 1'b0, 64'h0);
      n_cmp++; if (b_rd !== 64'h0000000000000001) begin n_bad++; $display("FAIL b_sbyte0f got %h want 1", b_rd); end
      b_set(7'h08, 2'b11, 1'b1, 1'b1, 1'b0, 64'h0);
      n_cmp++; if (b_rd !== 64'hFFFFFFFF89ABCDEF) begin
         n_bad++; $display("FAIL b_sword08 got %h want ffffffff89abcdef", b_rd); end
      b_set(7'h08, 2'b00, 1'b1, 1'b0, 1'b1, 64'h77);
      n_cmp++; if (b_rv !== 1'b0) begin n_bad++; $display("FAIL b_rw_same got rv=%b want 0", b_rv); end
      b_set(7'h08, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
      n_cmp++; if (b_rd !== 64'h77) begin n_bad++; $display("FAIL b_ubyte08 got %h want 77", b_rd); end
      b_set(7'h0C, 2'b11, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF);
      b_set(7'h08, 2'b10, 1'b1, 1'b0, 1'b0, 64'h0);
      n_cmp++; if (b_rd !== 64'hDEADBEEF89ABCD77) begin
         n_bad++; $display("FAIL b_dword got %h want deadbeef89abcd77", b_rd); end
      b_set(7'h04, 2'b10, 1'b1, 1'b0, 1'b0, 64'h0);
      n_cmp++; if (b_mis !== 1'b1 || b_rv !== 1'b0) begin
         n_bad++; $display("FAIL b_mis_dbl got mis=%b rv=%b want 1/0", b_mis, b_rv); end
   endtask

   task automatic test_dump();
      for (int i = 0; i < 4; i++) c_set(4'(i*4), 32'hC0DE0000 | i);
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      n_cmp++; if (c_busy !== 1'b1 || c_dv !== 1'b0) begin
         n_bad++; $display("FAIL dump_start got busy=%b dv=%b want 1/0", c_busy, c_dv); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         $display("D addr=%0d data=%h valid=%b done=%b", c_daddr, c_ddata, c_dv, c_done);
         n_cmp++; if (c_dv !== 1'b1 || c_daddr !== 2'(i) || c_ddata !== (32'hC0DE0000 | i) ||
                      c_done !== (i == 3) || c_busy !== 1'b1) begin
            n_bad++; $display("FAIL dump_word%0d got v=%b a=%0d d=%h done=%b want 1/%0d/%h/%b",
                              i, c_dv, c_daddr, c_ddata, c_done, i, 32'hC0DE0000 | i, i == 3); end
         if (i == 1) c_start = 1'b1;
         if (i == 2) c_start = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (c_busy !== 1'b0 || c_dv !== 1'b0 || c_done !== 1'b0) begin
         n_bad++; $display("FAIL dump_end got busy=%b dv=%b done=%b want 0/0/0", c_busy, c_dv, c_done); end
   endtask

   task automatic test_reset_dump();
      bit found = 0;
      int seen = 0;
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (c_dv === 1'b1 && c_daddr === 2'd2) found = 1;
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL rd_reach2 got none want addr 2 within 10 cycles"); end
      #2 c_rst = 1'b1;
      #1;
      n_cmp++; if ({c_busy, c_dv, c_done, c_daddr, c_ddata} !== '0) begin
         n_bad++; $display("FAIL rd_abort got busy=%b dv=%b done=%b a=%0d d=%h want 0", c_busy, c_dv, c_done, c_daddr, c_ddata); end
      @(negedge clk);
      c_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (c_done === 1'b1 || c_dv === 1'b1 || c_busy === 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rd_quiet got %0d active cycles want 0", seen); end
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      @(negedge clk);
      n_cmp++; if (c_dv !== 1'b1 || c_daddr !== 2'd0 || c_ddata !== 32'hC0DE0000) begin
         n_bad++; $display("FAIL rd_restart got v=%b a=%0d d=%h want 1/0/c0de0000", c_dv, c_daddr, c_ddata); end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_extension();
      test_lanes();
      test_misaligned();
      test_back_to_back();
      test_64();
      test_dump();
      test_reset_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Parametrised data-memory front end for the pipeline MEM stage.
- Supports byte, half, word and (64-bit builds only) double accesses with per-lane write enables and sign or zero extension.
- Registered 1-cycle read with a valid strobe; misaligned accesses are registered and suppressed.
- Includes a debug-dump FSM that streams the whole memory out of a second read port without stalling the core port.

Parameters:
NB_DATA_BUS, 32, memory word width in bits; legal values 32 or 64.
N_ADDRESS, 128, memory size in bytes; must be a multiple of NB_DATA_BUS/8.
NB_ADDRESS, $clog2(N_ADDRESS), byte address width.
N_LANES, NB_DATA_BUS/8, byte lanes per word.
N_WORDS, N_ADDRESS/N_LANES, memory depth in words.
NB_WORD_ADDR, $clog2(N_WORDS), word address width.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_reset  in  1  asynchronous active-high reset.
i_addr  in  NB_ADDRESS  byte address of the core access.
i_addressing  in  2  access size: 00 byte, 01 half, 11 word(32b), 10 double (64b builds only).
i_r_en  in  1  core read request.
i_r_signing  in  1  1 = sign-extend, 0 = zero-extend the read result.
i_w_en  in  1  core write request.
i_w_data  in  NB_DATA_BUS  store data, right-aligned.
o_r_data  out  NB_DATA_BUS  extended read result, valid when o_r_valid.
o_r_valid  out  1  one-cycle strobe, read result available.
o_misaligned  out  1  one-cycle strobe, previous request was misaligned or illegal.
i_d_start  in  1  pulse that starts a debug dump.
o_d_busy  out  1  dump in progress.
o_d_valid  out  1  o_d_addr / o_d_r_data hold a dumped word.
o_d_addr  out  NB_WORD_ADDR  word index being dumped.
o_d_r_data  out  NB_DATA_BUS  dumped word.
o_d_done  out  1  one-cycle strobe after the last word.

Behaviour:
Reset values:
- All outputs reset to 0. FSM resets to IDLE and the dump counter to 0.
- Memory contents are not reset.
- Reset mid-dump or mid-read aborts immediately; no o_d_done or o_r_valid follows.

Alignment (combinational on request):
- byte: always legal.
- half: requires addr[0]=0.
- word: requires addr[1:0]=0.
- double: requires addr[2:0]=0 and NB_DATA_BUS=64; when NB_DATA_BUS=32, code 10 is illegal.
- Illegal or misaligned request with r_en|w_en: no memory write, no o_r_valid; o_misaligned=1 the next cycle.

Lane selection:
- Lane index = addr[$clog2(N_LANES)-1:0] >> log2(size).
- Write: i_w_data low bits are replicated into the selected lanes; only those lane write enables are asserted, other lanes are untouched.
- A word access on a 64-bit bus uses lanes [3:0] or [7:4] according to addr[2].

Read:
- Request accepted at edge N: RAM output plus a registered copy of {lane offset, size, signing} are captured.
- The extended result is driven combinationally from those registers.
- o_r_valid=1 and o_r_data are valid for exactly one cycle after edge N; otherwise o_r_data holds its last value.
- Extension fills bits above the access size with the MSB of the selected field (signing=1) or with 0.
- Word and double reads on a 64-bit bus extend to 64 bits.

Simultaneous events:
- r_en and w_en in the same cycle: the write wins, the read is dropped, o_r_valid=0.
- A write at N followed by a read of the same address at N+1 returns the new data.
- Back-to-back reads produce back-to-back valids.

Debug FSM (states IDLE, DUMP, DONE):
- IDLE -> DUMP on i_d_start; the counter clears to 0.
- In DUMP, each cycle reads word[counter] on the second port. One cycle later o_d_valid=1 with o_d_addr=counter and o_d_r_data=word.
- The counter increments each cycle; on counter = N_WORDS-1 the FSM goes to DONE.
- DONE lasts one cycle: the last valid is emitted and o_d_done=1; then IDLE.
- o_d_busy=1 in DUMP and DONE.
- i_d_start while busy is ignored.
- A core write during a dump is permitted; the dumped word reflects RAM contents at its read edge.
- Debug reads never stall or alter the core port.

Test Plan:
- 32b: write word 0x8899AABB @0x10, read signed byte @0x13 -> o_r_data=0xFFFFFF88 one cycle later; unsigned half @0x12 -> 0x00008899.
- 32b: write byte 0x5A @0x21 over word 0x11223344 @0x20, read word @0x20 -> 0x11225A44 (other lanes untouched).
- 32b: read word @0x06 -> o_misaligned pulse, no o_r_valid; code 10 @0x08 -> o_misaligned; write half @0x03 -> memory unchanged.
- 64b build: write double 0x0123456789ABCDEF @0x08, signed word read @0x0C -> 0x0000000001234567; signed byte @0x0F -> 0x0000000000000001; same cycle r_en+w_en -> no valid.
- Dump with N_ADDRESS=16 (4 words preloaded 0..3): i_d_start -> 4 consecutive o_d_valid with addr 0,1,2,3, o_d_done on the 4th; a second start mid-dump is ignored.
- Assert i_reset during the dump at word 2 -> all o_d_* drop to 0 immediately, FSM back in IDLE, no o_d_done; a new start after reset dumps from addr 0.
